// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered flags, standard or first-word-fall-through read,
// and write-to-read bypass so a word written into the slot being read is returned directly.
module sync_fifo #(
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned FWFT       = 0,
    parameter int unsigned AF_LEVEL   = (2 ** ADDR_WIDTH) - 1,
    parameter int unsigned AE_LEVEL   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  wr_en,
    output logic                  full,
    output logic                  almost_full,
    output logic                  overflow,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  valid,
    output logic                  empty,
    output logic                  almost_empty,
    output logic                  underflow,
    output logic [ADDR_WIDTH:0]   count
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [ADDR_WIDTH:0]   wptr_q, wptr_d;
    logic [ADDR_WIDTH:0]   rptr_q, rptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  full_q, full_d;
    logic                  empty_q, empty_d;
    logic                  af_q, af_d;
    logic                  ae_q, ae_d;
    logic                  ovf_q, unf_q;
    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic [DATA_WIDTH-1:0] rd_word;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  wr_acc, rd_acc;
    logic                  load;

    always_comb begin
        wr_acc  = wr_en & ~full_q;
        rd_acc  = rd_en & ~empty_q;
        wptr_d  = wptr_q + {{ADDR_WIDTH{1'b0}}, wr_acc};
        rptr_d  = rptr_q + {{ADDR_WIDTH{1'b0}}, rd_acc};
        count_d = wptr_d - rptr_d;
        // Same slot index with differing wrap bits means every entry is occupied.
        full_d  = (wptr_d[ADDR_WIDTH] != rptr_d[ADDR_WIDTH]) &&
                  (wptr_d[ADDR_WIDTH-1:0] == rptr_d[ADDR_WIDTH-1:0]);
        empty_d = (wptr_d == rptr_d);
        af_d    = 32'(count_d) >= AF_LEVEL;
        ae_d    = 32'(count_d) <= AE_LEVEL;
    end

    // FWFT prefetches the next head every cycle; standard mode reads the head on demand.
    always_comb begin
        rd_addr = (FWFT != 0) ? rptr_d[ADDR_WIDTH-1:0] : rptr_q[ADDR_WIDTH-1:0];
        rd_word = (wr_acc && (wptr_q[ADDR_WIDTH-1:0] == rd_addr)) ? din : mem[rd_addr];
        load    = (FWFT != 0) ? ~empty_d : rd_acc;
        valid_d = load;
        dout_d  = dout_q;
        if (load) begin
            dout_d = rd_word;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wptr_q[ADDR_WIDTH-1:0]] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            af_q    <= 1'b0;
            ae_q    <= 1'b1;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            valid_q <= 1'b0;
            dout_q  <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            full_q  <= full_d;
            empty_q <= empty_d;
            af_q    <= af_d;
            ae_q    <= ae_d;
            ovf_q   <= wr_en & full_q;
            unf_q   <= rd_en & empty_q;
            valid_q <= valid_d;
            dout_q  <= dout_d;
        end
    end

    assign full         = full_q;
    assign almost_full  = af_q;
    assign overflow     = ovf_q;
    assign dout         = dout_q;
    assign valid        = valid_q;
    assign empty        = empty_q;
    assign almost_empty = ae_q;
    assign underflow    = unf_q;
    assign count        = count_q;

endmodule

// File: tb/tb_sync_fifo.sv
// Drives a standard-mode and an FWFT-mode FIFO with identical stimulus and checks both
// against a queue-based scoreboard.
module tb_sync_fifo;

    logic       clk;
    logic       rst;
    logic [7:0] din;
    logic       wr_en;
    logic       rd_en;

    logic       s_full, s_af, s_ovf, s_valid, s_empty, s_ae, s_unf;
    logic [7:0] s_dout;
    logic [2:0] s_count;
    logic       f_full, f_af, f_ovf, f_valid, f_empty, f_ae, f_unf;
    logic [7:0] f_dout;
    logic [2:0] f_count;

    int         n_vec;
    int         n_err;
    logic [7:0] q[$];
    logic [7:0] last;

    sync_fifo #(
        .ADDR_WIDTH(2), .DATA_WIDTH(8), .FWFT(0), .AF_LEVEL(3), .AE_LEVEL(1)
    ) u_std (
        .clk(clk), .rst(rst), .din(din), .wr_en(wr_en), .full(s_full),
        .almost_full(s_af), .overflow(s_ovf), .rd_en(rd_en), .dout(s_dout),
        .valid(s_valid), .empty(s_empty), .almost_empty(s_ae), .underflow(s_unf),
        .count(s_count)
    );

    sync_fifo #(
        .ADDR_WIDTH(2), .DATA_WIDTH(8), .FWFT(1), .AF_LEVEL(3), .AE_LEVEL(1)
    ) u_fwft (
        .clk(clk), .rst(rst), .din(din), .wr_en(wr_en), .full(f_full),
        .almost_full(f_af), .overflow(f_ovf), .rd_en(rd_en), .dout(f_dout),
        .valid(f_valid), .empty(f_empty), .almost_empty(f_ae), .underflow(f_unf),
        .count(f_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_reset();
        check("rst_s_count", 32'(s_count), 32'd0);
        check("rst_f_count", 32'(f_count), 32'd0);
        check("rst_s_empty", 32'(s_empty), 32'd1);
        check("rst_f_empty", 32'(f_empty), 32'd1);
        check("rst_s_ae", 32'(s_ae), 32'd1);
        check("rst_f_ae", 32'(f_ae), 32'd1);
        check("rst_s_full", 32'(s_full), 32'd0);
        check("rst_f_full", 32'(f_full), 32'd0);
        check("rst_s_af", 32'(s_af), 32'd0);
        check("rst_f_af", 32'(f_af), 32'd0);
        check("rst_s_ovf", 32'(s_ovf), 32'd0);
        check("rst_s_unf", 32'(s_unf), 32'd0);
        check("rst_f_ovf", 32'(f_ovf), 32'd0);
        check("rst_f_unf", 32'(f_unf), 32'd0);
        check("rst_s_valid", 32'(s_valid), 32'd0);
        check("rst_f_valid", 32'(f_valid), 32'd0);
        check("rst_s_dout", 32'(s_dout), 32'd0);
        check("rst_f_dout", 32'(f_dout), 32'd0);
    endtask

    // One clock: drive request, update scoreboard after the edge, compare both DUTs.
    task automatic step(input logic w, input logic r, input logic [7:0] d);
        logic wacc, racc, eovf, eunf;
        int   n;
        wr_en = w;
        rd_en = r;
        din   = d;
        eovf  = w && (q.size() == 4);
        eunf  = r && (q.size() == 0);
        wacc  = w && !eovf;
        racc  = r && !eunf;
        @(posedge clk);
        #1;
        if (racc) last = q.pop_front();
        if (wacc) q.push_back(d);
        wr_en = 1'b0;
        rd_en = 1'b0;
        n = q.size();
        check("s_count", 32'(s_count), 32'(n));
        check("f_count", 32'(f_count), 32'(n));
        check("s_full", 32'(s_full), 32'(n == 4));
        check("f_full", 32'(f_full), 32'(n == 4));
        check("s_empty", 32'(s_empty), 32'(n == 0));
        check("f_empty", 32'(f_empty), 32'(n == 0));
        check("s_af", 32'(s_af), 32'(n >= 3));
        check("f_af", 32'(f_af), 32'(n >= 3));
        check("s_ae", 32'(s_ae), 32'(n <= 1));
        check("f_ae", 32'(f_ae), 32'(n <= 1));
        check("s_ovf", 32'(s_ovf), 32'(eovf));
        check("f_ovf", 32'(f_ovf), 32'(eovf));
        check("s_unf", 32'(s_unf), 32'(eunf));
        check("f_unf", 32'(f_unf), 32'(eunf));
        check("s_valid", 32'(s_valid), 32'(racc));
        check("s_dout", 32'(s_dout), 32'(last));
        check("f_valid", 32'(f_valid), 32'(n != 0));
        if (n != 0) check("f_dout", 32'(f_dout), 32'(q[0]));
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        last  = 8'h00;
        rst   = 1'b1;
        din   = 8'h00;
        wr_en = 1'b0;
        rd_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset();
        #3 rst = 1'b0;

        // Fill, overflow, drain, underflow.
        step(1'b1, 1'b0, 8'h11);
        step(1'b1, 1'b0, 8'h22);
        step(1'b1, 1'b0, 8'h33);
        step(1'b1, 1'b0, 8'h44);
        step(1'b1, 1'b0, 8'h55);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b0, 8'h00);

        // Single word into empty FIFO, then pop it.
        step(1'b1, 1'b0, 8'hA5);
        step(1'b0, 1'b1, 8'h00);

        // Steady-state simultaneous read/write at count 2 across pointer wrap.
        step(1'b1, 1'b0, 8'hE0);
        step(1'b1, 1'b0, 8'hE1);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 8'(i));

        // Simultaneous requests at empty and at full.
        while (q.size() != 0) step(1'b0, 1'b1, 8'h00);
        step(1'b1, 1'b1, 8'hC0);
        for (int i = 1; i < 4; i++) step(1'b1, 1'b0, 8'(8'hC0 + i));
        step(1'b1, 1'b1, 8'hCF);
        while (q.size() != 0) step(1'b0, 1'b1, 8'h00);

        // Asynchronous reset mid-operation with requests pending.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'(8'h90 + i));
        #1;
        rst   = 1'b1;
        wr_en = 1'b1;
        rd_en = 1'b1;
        #1;
        check_reset();
        @(posedge clk);
        #1;
        check_reset();
        rst   = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        q.delete();
        last = 8'h00;
        step(1'b1, 1'b0, 8'h77);
        step(1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b0, 8'h00);

        // Random interleaving.
        for (int i = 0; i < 300; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sync_fifo.md
SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 4: log2 of depth; DEPTH = 2**ADDR_WIDTH entries.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: word width.
REQ-003 SHALL have parameter FWFT, default 0:
  - 1 = first-word-fall-through.
  - 0 = standard read with one-cycle latency.
REQ-004 SHALL have parameter AF_LEVEL, default DEPTH-1: almost_full threshold (count >= AF_LEVEL).
REQ-005 SHALL have parameter AE_LEVEL, default 1: almost_empty threshold (count <= AE_LEVEL).
REQ-006 SHALL have ports, in this order:
  - clk  input  1  clock; one clock, all logic on the rising edge.
  - rst  input  1  reset; asynchronous, active-high.
  - din  input  DATA_WIDTH  write data.
  - wr_en  input  1  write request.
  - full  output  1  no free entry.
  - almost_full  output  1  count >= AF_LEVEL.
  - overflow  output  1  one-cycle pulse; write was rejected.
  - rd_en  input  1  read request (FWFT=1: pop the head).
  - dout  output  DATA_WIDTH  read data.
  - valid  output  1  dout holds a newly read word.
  - empty  output  1  no readable word.
  - almost_empty  output  1  count <= AE_LEVEL.
  - underflow  output  1  one-cycle pulse; read was rejected.
  - count  output  ADDR_WIDTH+1  occupancy, 0..DEPTH.

Function
REQ-007 SHALL store up to DEPTH words in a simple dual-port array: one write port, one registered read port.
REQ-008 A write SHALL be accepted when wr_en=1 and full=0, storing din at wptr; wptr increments modulo DEPTH.
REQ-009 A read SHALL be accepted when rd_en=1 and empty=0; rptr increments modulo DEPTH.
REQ-010 Rejection pulses:
  - wr_en=1 with full=1 SHALL leave state unchanged and pulse overflow next cycle.
  - rd_en=1 with empty=1 SHALL do the same and pulse underflow next cycle.
REQ-011 count SHALL equal accepted writes minus accepted reads.
  - Simultaneous accepted read and write leave count unchanged.
  - Pointers SHALL be ADDR_WIDTH+1 bits; full and empty SHALL be derived from the wrap bit, not from count arithmetic overflow.
REQ-012 full SHALL be registered and equal (count==DEPTH); a write when full is rejected even if a read is accepted the same cycle.
REQ-013 empty SHALL be registered and equal (count==0); a read when empty is rejected even if a write is accepted the same cycle.
REQ-014 almost_full and almost_empty SHALL be registered and update in the same cycle as count.
REQ-015 Standard mode (FWFT=0):
  - An accepted read at edge N SHALL present the head word on dout with valid=1 in the cycle after edge N.
  - valid SHALL be 0 otherwise; dout holds its last value.
REQ-016 FWFT mode (FWFT=1):
  - Whenever empty=0, dout SHALL already show the head word.
  - valid SHALL equal !empty.
  - rd_en pops the head; the next word SHALL appear on dout in the following cycle.
REQ-017 Write-to-read latency SHALL be one cycle in both modes: a word written at edge N into an empty FIFO makes empty=0 after edge N.
  - In FWFT mode that word SHALL be on dout after edge N.
REQ-018 Read-during-write to the same entry (simultaneous accepted write and read, or write to the slot being prefetched) SHALL return the newly written data, via bypass of the array.
REQ-019 Wrap-around of both pointers SHALL be seamless; data order SHALL be strictly first-in first-out for any interleaving.
REQ-020 The array contents SHALL NOT be reset; only pointers, flags and output registers are reset.

Reset
REQ-021 On rst=1, asynchronously:
  - count=0, empty=1, almost_empty=1 (AE_LEVEL>=0), full=0, almost_full=0.
  - overflow=0, underflow=0, valid=0, dout=0.
  - Both pointers =0.
REQ-022 rst asserted mid-operation SHALL discard all stored words, and no overflow/underflow pulse SHALL be generated for requests during reset.
  - The first accepted write after deassertion SHALL be the first word read.
REQ-023 wr_en/rd_en in the first edge after rst deassertion SHALL be honoured normally.

Verification
REQ-024 ADDR_WIDTH=2, DATA_WIDTH=8, FWFT=0: write 0x11,0x22,0x33,0x44 -> full=1, count=4. A fifth write of 0x55 -> overflow pulse, count stays 4. Four reads -> dout 0x11,0x22,0x33,0x44 with valid each cycle after the read, then empty=1.
REQ-025 FWFT=1, empty FIFO: write 0xA5 at edge N -> after edge N dout=0xA5, valid=1, empty=0. rd_en next cycle -> empty=1, count=0.
REQ-026 Count=2, simultaneous wr_en=1 and rd_en=1 for 10 cycles with data 0..9 -> count stays 2, reads return the 2 prior words then 0..7 in order, pointers wrap without error.
REQ-027 Count=0, wr_en=1 and rd_en=1 same edge -> write accepted, read rejected, underflow=1 one cycle, count=1. Count=4, same stimulus -> read accepted, write rejected, overflow=1, count=3.
REQ-028 AF_LEVEL=3, AE_LEVEL=1: fill 0->4 -> almost_empty drops at count=2, almost_full rises at count=3. Drain -> the reverse transitions.
REQ-029 Count=3, assert rst for one cycle between edges -> all outputs take their reset values immediately. Write 0x77 then read -> dout=0x77.
